contador_eventos: RTL
=====================

# contador_eventos

Modulo-N up/down event counter that sits directly downstream of the single-bit D flip-flop stage in the counter datapath. It consumes that stage's registered `q` output as an event line, detects each rising edge, and advances a bounded count. It reports a one-cycle terminal-count pulse and a sticky overflow flag. It supports synchronous parallel load and count enable.

## Interface
- `WIDTH`, default 4: count register width in bits.
- `MODULO`, default 10: count range is 0..MODULO-1. Legal range is 2 <= MODULO <= 2^WIDTH.

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `r`, in, 1: reset, asynchronous and active-high.
- `ev`, in, 1: event line, driven by the upstream flip-flop `q`.
- `en`, in, 1: count enable; gates event-driven counting only.
- `up`, in, 1: direction; 1 counts up, 0 counts down.
- `ld`, in, 1: synchronous load strobe.
- `ld_val`, in, WIDTH: load value.
- `clr_ovf`, in, 1: clears the sticky overflow flag.
- `cnt`, out, WIDTH: current count, registered.
- `tc`, out, 1: terminal-count pulse, registered, high for one cycle on each wrap.
- `ovf`, out, 1: sticky wrap flag, registered.

## Operation
- Edge detect:
  - `ev_d` registers the sampled event.
  - `pulse = ev_s & ~ev_d`, where `ev_s` is `ev` itself, or the synchronizer output when `CONTADOR_EVENTOS_SYNC_EN` is defined.
- Priority on each rising `clk` edge: `ld`, then count, then hold.
  - `ld=1`: `cnt <= ld_val` if `ld_val < MODULO`, else `cnt <= MODULO-1`. `tc <= 0`. `ovf <= 0`. Any pulse arriving on that edge is discarded.
  - `ld=0`, `en=1`, `pulse=1`, `up=1`: `cnt <= (cnt==MODULO-1) ? 0 : cnt+1`.
  - `ld=0`, `en=1`, `pulse=1`, `up=0`: `cnt <= (cnt==0) ? MODULO-1 : cnt-1`.
  - Otherwise `cnt` holds.
- A wrap is MODULO-1 -> 0 when counting up, or 0 -> MODULO-1 when counting down.
  - `tc <= 1` on the wrap edge only, 0 on all other edges.
- `ovf` is set on any wrap and cleared by `clr_ovf`. If `clr_ovf` and a wrap occur on the same edge, set wins.
- A pulse with `en=0` is consumed, not deferred: `ev_d` still updates.
- Arithmetic stays within WIDTH bits. No intermediate value reaches MODULO.

## Timing
- Reset (asynchronous, immediate):
  - `cnt=0`, `tc=0`, `ovf=0`.
  - `ev_d=1` and synchronizer flops `=1`, so an `ev` already high at reset release does not count.
- Latency, macro undefined: `cnt` and `tc` update on the first rising edge that samples `ev=1` after a sampled 0.
- Latency, macro defined: update occurs 2 edges later (third sampling edge).
- Minimum event spacing:
  - `ev` must be sampled low on at least one edge between events.
  - With the synchronizer, `ev` must be stable for at least 2 cycles per level.
- `up` and `en` are sampled on the same edge as `pulse`. Changing `up` mid-stream takes effect on the next pulse.
- Reset asserted mid-count forces the reset values within the same cycle. No pending pulse survives reset.

## Configuration
- `CONTADOR_EVENTOS_SYNC_EN` defined: two-flop synchronizer on `ev` ahead of the edge detector, for an asynchronous or foreign-clock upstream. Adds 2 cycles of latency.
- `CONTADOR_EVENTOS_SYNC_EN` undefined: `ev` feeds the edge detector directly. `ev` must already be synchronous to `clk`, which is the case for the in-domain flip-flop stage.

## Structure
- Package `contador_pkg`:
  - `WIDTH` and `MODULO` defaults.
  - Direction constants `DIR_UP=1`, `DIR_DN=0`.
  - Function `clamp_load(val, modulo)`.
- Sub-module `edge_sync`:
  - Optional synchronizer (macro-controlled), `ev_d` register and rising-edge `pulse`.
  - Reset preloads its flops to 1.
- Top level holds the count, wrap, `tc` and `ovf` logic only.

## Test plan
- Reset with `ev=1`, then release, hold `ev=1` for 5 cycles -> `cnt` stays 0, `tc=0`, `ovf=0`.
- `up=1`, `en=1`, 12 isolated `ev` pulses, MODULO=10 -> `cnt` runs 1..9, 0, 1, 2. `tc` is high exactly on the 9->0 edge. `ovf=1` afterwards.
- `up=0` from `cnt=0`, one pulse -> `cnt=9`, `tc=1` for one cycle. Next pulse -> `cnt=8`, `tc=0`.
- `ld=1` with `ld_val=13` (MODULO=10) on the same edge as a pulse -> `cnt=9`, `ovf=0`, pulse ignored. `ld_val=4` -> `cnt=4`.
- `en=0` with 3 pulses -> `cnt` unchanged. Re-enable while `ev` is still high -> no count until the next rising edge of `ev`.
- `clr_ovf=1` on the wrap edge -> `ovf` stays 1. `clr_ovf` on the following cycle -> `ovf=0`. With the macro defined, a pulse shows on `cnt` exactly 2 cycles later than without.

Source files
------------

// File: rtl/contador_pkg.sv
// contador_pkg: shared defaults, direction encoding and load clamping for
// the contador_eventos event counter.
package contador_pkg;

    // Default geometry: a decade counter in a 4-bit register.
    localparam int unsigned WIDTH_DEF  = 4;
    localparam int unsigned MODULO_DEF = 10;

    // Encoding of the 'up' input.
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Load values at or above the modulo saturate to the top of the range,
    // so the count register never holds an out-of-range value.
    function automatic int unsigned clamp_load(input int unsigned val,
                                               input int unsigned modulo);
        return (val < modulo) ? val : modulo - 1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// edge_sync: rising-edge detector on the event line.
// Build option: define CONTADOR_EVENTOS_SYNC_EN to add a two-flop
// synchronizer ahead of the detector for an event line that is not
// synchronous to clk (adds two cycles of latency).
// All flops reset to 1 so a line that is already high when reset is
// released is not mistaken for a fresh event.
module edge_sync (
    input  logic clk,
    input  logic r,
    input  logic ev,
    output logic pulse
);

    logic ev_s;
    logic ev_d;

`ifdef CONTADOR_EVENTOS_SYNC_EN
    logic sync1;
    logic sync2;

    // Two-flop synchronizer bringing ev into the clk domain.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= ev;
            sync2 <= sync1;
        end
    end

    assign ev_s = sync2;
`else
    assign ev_s = ev;
`endif

    // Delayed copy of the sampled event; updates regardless of enable so a
    // suppressed event is consumed rather than deferred.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            ev_d <= 1'b1;
        end else begin
            ev_d <= ev_s;
        end
    end

    assign pulse = ev_s & ~ev_d;

endmodule

// File: rtl/contador_eventos.sv
// contador_eventos: modulo-MODULO up/down event counter with synchronous
// load, count enable, one-cycle terminal-count pulse and sticky overflow.
// Build option: CONTADOR_EVENTOS_SYNC_EN (see edge_sync) inserts an input
// synchronizer on ev.
// Priority per edge: load, then counting, then hold. A load discards any
// event arriving on the same edge and clears tc and ovf.
module contador_eventos
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned MODULO = MODULO_DEF
) (
    input  logic             clk,
    input  logic             r,
    input  logic             ev,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);

    logic             pulse;
    logic             step;
    logic             wrap;
    logic [WIDTH-1:0] nxt;

    edge_sync u_edge_sync (
        .clk   (clk),
        .r     (r),
        .ev    (ev),
        .pulse (pulse)
    );

    // Next count and wrap detection; the wrap compares against the range
    // ends so no intermediate value ever reaches MODULO.
    always_comb begin
        step = ~ld & en & pulse;
        wrap = 1'b0;
        nxt  = cnt;
        if (up == DIR_UP) begin
            wrap = step & (cnt == MAX);
            nxt  = (cnt == MAX) ? '0 : cnt + WIDTH'(1);
        end else begin
            wrap = step & (cnt == '0);
            nxt  = (cnt == '0) ? MAX : cnt - WIDTH'(1);
        end
    end

    // Count register, terminal-count pulse and sticky overflow (set beats clear).
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            cnt <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (ld) begin
            cnt <= WIDTH'(clamp_load(32'(ld_val), MODULO));
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            tc <= wrap;
            if (step) begin
                cnt <= nxt;
            end
            if (wrap) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule
